spi_mstr16: RTL and testbench

- 16-bit SPI master that performs one full-duplex transaction per request.
- Sits directly upstream of the inertial interface: that block's sequencer issues config writes and ptch/AZ reads through it, and consumes rd_data/done.
- Drives the physical SS_n/SCLK/MOSI pins to the inertial sensor and samples MISO.
- SPI mode 3: SCLK idles high; MOSI changes on SCLK fall; MISO is sampled at SCLK rise.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_mstr16.sv | 125 ++++++++++++
 tb/tb_spi_mstr16.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the spi_mstr16 SPI master.
//   spi_state_t      : controller state encoding
//   SCLK_IDLE_PRESET : divider value held while idle (SCLK=1, 8 clk front porch)
//   SMPL_PT          : divider value at which MISO is captured (SCLK about to rise)
//   SHFT_PT          : divider value at which the shift register advances (SCLK about to fall)
//   NBITS_DEF        : default transaction length
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   localparam logic [4:0] SCLK_IDLE_PRESET = 5'b10111;
   localparam logic [4:0] SMPL_PT          = 5'b01111;
   localparam logic [4:0] SHFT_PT          = 5'b11111;
   localparam int         NBITS_DEF        = 16;

endpackage

// File: rtl/spi_mstr16.sv
// spi_mstr16: SPI mode-3 master, one full-duplex NBITS-bit transaction per wrt.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   wrt     in   single-cycle start request, accepted only while idle
//   cmd     in   word to send, MSB first, captured on the accepting edge
//   done    out  set when a transaction completes, cleared by the next accepted wrt
//   rd_data out  received word, MSB first, valid while done=1
//   SS_n    out  slave select, active-low
//   SCLK    out  serial clock, idles high
//   MOSI    out  serial data out, changes on SCLK fall
//   MISO    in   serial data in, sampled on SCLK rise (must already be synchronous)
//
// state  | meaning
// IDLE   | SS_n high, divider parked at preset, waiting for wrt
// ACTIVE | SS_n low, divider running, shifting NBITS bits
module spi_mstr16
   import spi_pkg::*;
#(
   parameter int DIV_W = 5,
   parameter int NBITS = NBITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrt,
   input  logic [NBITS-1:0] cmd,
   output logic             done,
   output logic [NBITS-1:0] rd_data,
   output logic             SS_n,
   output logic             SCLK,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int CNT_W = $clog2(NBITS + 1);

   // Divider landmarks for any DIV_W; at DIV_W=5 these equal the package
   // constants 10111 / 01111 / 11111.
   localparam logic [DIV_W-1:0] DIV_ONES = {DIV_W{1'b1}};
   localparam logic [DIV_W-1:0] DIV_PRESET = DIV_ONES ^ (DIV_W'(1) << (DIV_W - 2));
   localparam logic [DIV_W-1:0] DIV_SMPL = DIV_ONES >> 1;
   localparam logic [DIV_W-1:0] DIV_SHFT = DIV_ONES;

   spi_state_t       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [NBITS-1:0] shft_q, shft_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             smp_seen_q, smp_seen_d;
   logic             miso_smp_q, miso_smp_d;
   logic             ss_n_q, ss_n_d;
   logic             done_q, done_d;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      shft_d     = shft_q;
      bit_cnt_d  = bit_cnt_q;
      smp_seen_d = smp_seen_q;
      miso_smp_d = miso_smp_q;
      ss_n_d     = ss_n_q;
      done_d     = done_q;
      case (state_q)
         IDLE: begin
            div_d = DIV_PRESET;
            if (wrt) begin
               shft_d     = cmd;
               ss_n_d     = 1'b0;
               done_d     = 1'b0;
               bit_cnt_d  = '0;
               smp_seen_d = 1'b0;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            div_d = div_q + 1'b1;
            if (div_q == DIV_SMPL) begin
               miso_smp_d = MISO;
               smp_seen_d = 1'b1;
            end
            // The first SCLK fall precedes any sample (front porch) and must not shift.
            if (div_q == DIV_SHFT && smp_seen_q) begin
               shft_d    = {shft_q[NBITS-2:0], miso_smp_q};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
                  // Re-parking the divider suppresses the SCLK fall that would follow.
                  state_d = IDLE;
                  ss_n_d  = 1'b1;
                  done_d  = 1'b1;
                  div_d   = DIV_PRESET;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_q      <= DIV_PRESET;
         shft_q     <= '0;
         bit_cnt_q  <= '0;
         smp_seen_q <= 1'b0;
         miso_smp_q <= 1'b0;
         ss_n_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         shft_q     <= shft_d;
         bit_cnt_q  <= bit_cnt_d;
         smp_seen_q <= smp_seen_d;
         miso_smp_q <= miso_smp_d;
         ss_n_q     <= ss_n_d;
         done_q     <= done_d;
      end
   end

   assign SCLK    = div_q[DIV_W-1];
   assign MOSI    = shft_q[NBITS-1];
   assign rd_data = shft_q;
   assign SS_n    = ss_n_q;
   assign done    = done_q;

endmodule

// File: tb/tb_spi_mstr16.sv
module tb_spi_mstr16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wrt = 1'b0;
   logic [15:0] cmd = 16'h0000;
   logic        done;
   logic [15:0] rd_data;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

   int checks = 0;
   int errors = 0;

   spi_mstr16 dut (
      .clk     (clk),
      .rst     (rst),
      .wrt     (wrt),
      .cmd     (cmd),
      .done    (done),
      .rd_data (rd_data),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .MISO    (MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Slave: loopback, or a mode-3 slave returning slave_resp and recording MOSI.
   bit          loop_mode   = 1'b1;
   logic [15:0] slave_resp  = 16'h0000;
   logic [15:0] slave_sr    = 16'h0000;
   logic [15:0] slave_cap   = 16'h0000;
   int          slave_rises = 0;

   assign MISO = loop_mode ? MOSI : slave_sr[15];

   always @(negedge SS_n) begin
      slave_sr    <= slave_resp;
      slave_cap   <= 16'h0000;
      slave_rises <= 0;
   end

   always @(posedge SCLK) begin
      if (!SS_n) begin
         slave_cap   <= {slave_cap[14:0], MOSI};
         slave_rises <= slave_rises + 1;
      end
   end

   always @(negedge SCLK) begin
      if (slave_rises > 0) slave_sr <= slave_sr << 1;
   end

   // Reference model: a transaction is a 521-cycle window after the accepting
   // edge; pin values follow from the cycle offset within that window.
   bit          m_act  = 1'b0;
   bit          m_done = 1'b0;
   int          m_k    = 0;
   logic [15:0] m_cmd  = 16'h0000;
   logic [15:0] m_rx   = 16'h0000;
   logic [15:0] m_rd   = 16'h0000;

   initial begin
      int  nsh;
      logic e_ss, e_sclk, e_mosi;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_rd   = 16'h0000;
         end else if (m_act) begin
            m_k++;
            if (m_k == 521) begin
               m_act  = 1'b0;
               m_done = 1'b1;
               m_rd   = m_rx;
            end
         end else if (wrt) begin
            m_act  = 1'b1;
            m_k    = 0;
            m_cmd  = cmd;
            m_rx   = loop_mode ? cmd : slave_resp;
            m_done = 1'b0;
         end
         #1;
         if (m_act) begin
            e_ss   = 1'b0;
            e_sclk = (((23 + m_k) % 32) >= 16);
            nsh    = (m_k < 41) ? 0 : ((m_k - 41) / 32 + 1);
            e_mosi = m_cmd[15 - nsh];
         end else begin
            e_ss   = 1'b1;
            e_sclk = 1'b1;
            e_mosi = m_rd[15];
         end
         chk("m_ss_n", 32'(SS_n), 32'(e_ss));
         chk("m_sclk", 32'(SCLK), 32'(e_sclk));
         chk("m_mosi", 32'(MOSI), 32'(e_mosi));
         chk("m_done", 32'(done), 32'(m_done));
         if (!m_act) chk("m_rd_data", 32'(rd_data), 32'(m_rd));
      end
   end

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns just after edge 0 of the new transaction.
   task automatic start(input logic [15:0] c);
      @(negedge clk);
      wrt = 1'b1;
      cmd = c;
      @(negedge clk);
      wrt = 1'b0;
   endtask

   initial begin
      adv(3);
      chk("rst_ss_n", 32'(SS_n), 32'd1);
      chk("rst_sclk", 32'(SCLK), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd", 32'(rd_data), 32'h0);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      rst = 1'b0;

      // Loopback A5C3 with edge-exact timing.
      loop_mode = 1'b1;
      start(16'hA5C3);
      chk("t_ss_fall_e0", 32'(SS_n), 32'd0);
      adv(8);
      chk("t_sclk_e8", 32'(SCLK), 32'd1);
      adv(1);
      chk("t_sclk_fall_e9", 32'(SCLK), 32'd0);
      adv(15);
      chk("t_sclk_e24", 32'(SCLK), 32'd0);
      adv(1);
      chk("t_sclk_rise_e25", 32'(SCLK), 32'd1);
      adv(31);
      chk("t_sclk_e56", 32'(SCLK), 32'd0);
      adv(1);
      chk("t_sclk_rise_e57", 32'(SCLK), 32'd1);
      adv(463);
      chk("t_done_e520", 32'(done), 32'd0);
      chk("t_ss_e520", 32'(SS_n), 32'd0);
      adv(1);
      chk("t_done_e521", 32'(done), 32'd1);
      chk("t_ss_e521", 32'(SS_n), 32'd1);
      chk("t_sclk_e521", 32'(SCLK), 32'd1);
      chk("lb_rd_A5C3", 32'(rd_data), 32'hA5C3);

      // Slave returning 8F12 for command A400.
      loop_mode  = 1'b0;
      slave_resp = 16'h8F12;
      start(16'hA400);
      adv(521);
      chk("slv_done", 32'(done), 32'd1);
      chk("slv_rd_8F12", 32'(rd_data), 32'h8F12);
      chk("slv_rises", 32'(slave_rises), 32'd16);
      chk("slv_mosi_A400", 32'(slave_cap), 32'hA400);

      // wrt during an active transfer is ignored.
      loop_mode = 1'b1;
      start(16'h1234);
      adv(199);
      wrt = 1'b1;
      cmd = 16'hFFFF;
      adv(1);
      wrt = 1'b0;
      chk("ign_ss_e200", 32'(SS_n), 32'd0);
      adv(320);
      chk("ign_done_e520", 32'(done), 32'd0);
      adv(1);
      chk("ign_done_e521", 32'(done), 32'd1);
      chk("ign_rd_1234", 32'(rd_data), 32'h1234);

      // Reset mid-transfer aborts, then a fresh transfer completes.
      start(16'hBEEF);
      adv(299);
      rst = 1'b1;
      adv(1);
      rst = 1'b0;
      chk("abort_ss_n", 32'(SS_n), 32'd1);
      chk("abort_sclk", 32'(SCLK), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rd", 32'(rd_data), 32'h0);
      start(16'h00FF);
      adv(521);
      chk("post_rst_done", 32'(done), 32'd1);
      chk("post_rst_rd_00FF", 32'(rd_data), 32'h00FF);

      // Back-to-back: wrt held across the done edge and the one after.
      start(16'h5555);
      adv(520);
      wrt = 1'b1;
      cmd = 16'hAAAA;
      adv(1);
      chk("b2b_done_e521", 32'(done), 32'd1);
      chk("b2b_ss_e521", 32'(SS_n), 32'd1);
      chk("b2b_rd_5555", 32'(rd_data), 32'h5555);
      adv(1);
      wrt = 1'b0;
      chk("b2b_done_drop", 32'(done), 32'd0);
      chk("b2b_ss_low", 32'(SS_n), 32'd0);
      adv(520);
      chk("b2b_done_e520", 32'(done), 32'd0);
      adv(1);
      chk("b2b_done_e521b", 32'(done), 32'd1);
      chk("b2b_rd_AAAA", 32'(rd_data), 32'hAAAA);

      adv(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
